// File: rtl/serial_deframer.sv
// -----------------------------------------------------------------------------
// serial_deframer
//
// Turns a strobed serial bit stream into WIDTH-bit words. The block hunts for
// the SYNC pattern (MSB received first), locks on it, and then packs every
// following group of WIDTH bits into a word that is offered on a 1-deep
// valid/ready output register.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : asynchronous, active-high reset
//   clr        : synchronous soft clear, returns the block to HUNT
//   d_in       : serial data bit
//   d_en       : d_in is valid this cycle
//   dout       : assembled word, MSB = first received bit
//   dout_valid : dout holds an untransferred word
//   dout_ready : consumer accepts dout this cycle
//   locked     : high while in LOCK
//   overflow   : sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module serial_deframer #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             d_in,
    input  logic             d_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state_r;
    // Only the newest WIDTH-1 bits of history can ever reach a future window;
    // the oldest bit of the WIDTH-bit shift value falls out on the next shift.
    logic [WIDTH-2:0]  sr_r;
    logic [CW-1:0]     fill_r;
    logic [CW-1:0]     bit_cnt_r;
    logic [WIDTH-1:0]  dout_r;
    logic              dout_valid_r;
    logic              locked_r;
    logic              overflow_r;

    logic [WIDTH-1:0]  sr_next_s;
    logic              sync_hit_s;
    logic              word_done_s;
    logic              load_ok_s;

    // Next shift value, sync detection and word-completion decode.
    always_comb begin
        sr_next_s   = {sr_r, d_in};
        // fill counts bits before this one, so WIDTH-1 means this is bit WIDTH.
        sync_hit_s  = d_en && (state_r == ST_HUNT) &&
                      (fill_r >= CW'(WIDTH - 1)) && (sr_next_s == SYNC);
        word_done_s = d_en && (state_r == ST_LOCK) &&
                      (bit_cnt_r == CW'(WIDTH - 1));
        // Output register can take a word if empty or being drained now.
        load_ok_s   = !dout_valid_r || dout_ready;
    end

    // Framing FSM, counters and registered output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_HUNT;
            sr_r         <= {(WIDTH-1){1'b0}};
            fill_r       <= {CW{1'b0}};
            bit_cnt_r    <= {CW{1'b0}};
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (clr) begin
            // clr wins over any bit or completion; dout keeps its last value.
            state_r      <= ST_HUNT;
            sr_r         <= {(WIDTH-1){1'b0}};
            fill_r       <= {CW{1'b0}};
            bit_cnt_r    <= {CW{1'b0}};
            dout_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (d_en) begin
                sr_r <= sr_next_s[WIDTH-2:0];
                case (state_r)
                    ST_HUNT: begin
                        if (fill_r < CW'(WIDTH)) begin
                            fill_r <= fill_r + CW'(1);
                        end
                        if (sync_hit_s) begin
                            state_r   <= ST_LOCK;
                            locked_r  <= 1'b1;
                            bit_cnt_r <= {CW{1'b0}};
                        end
                    end
                    ST_LOCK: begin
                        if (bit_cnt_r == CW'(WIDTH - 1)) begin
                            bit_cnt_r <= {CW{1'b0}};
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_r   <= ST_HUNT;
                        locked_r  <= 1'b0;
                        fill_r    <= {CW{1'b0}};
                        bit_cnt_r <= {CW{1'b0}};
                    end
                endcase
            end

            if (word_done_s) begin
                if (load_ok_s) begin
                    dout_r       <= sr_next_s;
                    dout_valid_r <= 1'b1;
                end else begin
                    overflow_r   <= 1'b1;
                end
            end else if (dout_valid_r && dout_ready) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign locked     = locked_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Serial-to-parallel deframer that consumes the single-bit stream produced by the team's edge-registered flop stages and turns it into WIDTH-bit words.
- It hunts for a fixed sync pattern in the incoming bits, locks on it, then assembles each following group of WIDTH bits into a word.
- Each word is presented on a valid/ready output port.
- It sits directly downstream of the serial flop chain and feeds parallel consumers.

## Interface
- WIDTH, 8, word and sync-pattern width in bits (≥2)
- SYNC, 8'hA5, sync pattern, WIDTH bits, MSB received first
- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous soft clear; returns the block to HUNT
- d_in  input  1  serial data bit
- d_en  input  1  d_in is valid this cycle (bit strobe)
- dout  output  WIDTH  assembled word, MSB = first received bit
- dout_valid  output  1  dout holds an untransferred word
- dout_ready  input  1  consumer accepts dout this cycle
- locked  output  1  high while in LOCK state
- overflow  output  1  sticky: a completed word was dropped

## Operation
- Shift register sr (WIDTH bits): on each d_en, sr <= {sr[WIDTH-2:0], d_in}. sr_next denotes this shifted value.
- Fill counter (0..WIDTH, saturating): counts d_en bits since entry to HUNT. Sync cannot be detected before WIDTH bits have been received, even when SYNC == 0.
- Bit counter bit_cnt: 0..WIDTH-1, used in LOCK.
- State HUNT:
  - On d_en with fill ≥ WIDTH-1 and sr_next == SYNC: go to LOCK and set bit_cnt = 0.
  - Otherwise stay in HUNT, shifting bits.
- State LOCK:
  - Each d_en increments bit_cnt.
  - On the d_en where bit_cnt == WIDTH-1, the word is complete: word = sr_next, and bit_cnt wraps to 0.
  - A word equal to SYNC received in LOCK is ordinary data.
  - The block stays in LOCK until rst or clr.
- Output register, applied on a complete word:
  - If !dout_valid, or dout_valid && dout_ready in the same cycle: load dout = word and set dout_valid = 1.
  - Otherwise: drop the word, leave dout unchanged, set overflow = 1.
- Handshake:
  - A transfer occurs on dout_valid && dout_ready.
  - A transfer with no new word in the same cycle clears dout_valid.
  - dout must not change while dout_valid && !dout_ready.
- clr: priority over d_en and over a word completion.
  - Next state is HUNT; sr, fill and bit_cnt go to 0.
  - dout_valid, locked and overflow go to 0; dout keeps its value.
- Reset values: state HUNT, sr 0, fill 0, bit_cnt 0, dout 0, dout_valid 0, locked 0, overflow 0.
- Reset mid-word: the partial word is discarded and hunting restarts.

## Timing
- Registered outputs only; there is no combinational path from inputs to outputs.
- locked rises in the cycle after the posedge that samples the final sync bit.
- Word latency: dout_valid rises, with dout updated, in the cycle after the posedge that samples the WIDTH-th data bit.
- Gaps in d_en have no effect beyond delaying the sequence. With contiguous d_en, one word is produced every WIDTH cycles.
- A completion and a transfer on the same posedge give back-to-back valid words with no bubble and no overflow.
- overflow is set on the posedge of the dropped completion and holds until rst or clr.
- Throughput: 1 word per WIDTH enabled bits; the output buffer is 1 deep.

## Test plan
- Reset mid-stream:
  - Stimulus: assert rst asynchronously after 4 bits of a data word in LOCK.
  - Required response: locked, dout_valid, overflow and dout go to 0 immediately. After release, the block needs a full A5 before it locks again.
- Lock and deliver:
  - Stimulus: d_en=1 every cycle; bits 1010_0101 then 0011_1100; dout_ready=1.
  - Required response: locked=1 from the cycle after bit 8; dout=8'h3C and dout_valid=1 for exactly one cycle, in the cycle after bit 16.
- Backpressure and overflow:
  - Stimulus: dout_ready=0; after sync send 3C then 81.
  - Required response: dout stays 3C and overflow=1 after the 81 completes (81 is dropped). Raising dout_ready for 1 cycle clears dout_valid.
- Simultaneous transfer and completion:
  - Stimulus: dout_ready=1 only on the posedge where word 81 completes while 3C is pending.
  - Required response: dout=81, dout_valid stays 1, overflow stays 0.
- False-sync and gaps:
  - Stimulus: send 0101_0010_1 with random d_en gaps, then an A5 aligned one bit later.
  - Required response: lock only on the aligned A5; the following word decodes identically to the gap-free run.
- clr while locked:
  - Stimulus: assert clr in the same cycle as a word completion, with overflow=1.
  - Required response: no new dout_valid; locked=0; overflow=0; dout unchanged; the block is back in HUNT.
